cbuf_trig_ctrl: RTL and testbench

Write-side controller for the per-channel ADC circular buffer. While acquisition is enabled it advances the buffer write address on every clock. On each accepted trigger it computes the waveform start address, which is the write address minus the pre-trigger length. It waits until all post-trigger words are in the buffer, then pushes the start address into a first-word-fall-through (FWFT) trigger-address FIFO, which the acquisition sequencer pops via `trig_addr_rd_en`. Triggers that cannot be serviced are dropped and counted.

---
 rtl/cbuf_pkg.sv | 23 ++
 rtl/trig_addr_fifo.sv | 72 +++++++
 rtl/cbuf_trig_ctrl.sv | 157 +++++++++++++++
 tb/tb_cbuf_trig_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbuf_pkg.sv
// Shared definitions for the circular-buffer trigger controller: default widths
// and the one-hot state encoding of the write-side FSM.
package cbuf_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int FIFO_AW_DEF = 4;

  localparam int S_IDLE  = 0;
  localparam int S_PRIME = 1;
  localparam int S_ARMED = 2;
  localparam int S_POST  = 3;
  localparam int S_PUSH  = 4;
  localparam int NUM_ST  = 5;

  typedef enum logic [NUM_ST-1:0] {
    ST_IDLE  = 5'(1 << S_IDLE),
    ST_PRIME = 5'(1 << S_PRIME),
    ST_ARMED = 5'(1 << S_ARMED),
    ST_POST  = 5'(1 << S_POST),
    ST_PUSH  = 5'(1 << S_PUSH)
  } cbuf_state_e;

endpackage

// File: rtl/trig_addr_fifo.sv
// First-word-fall-through FIFO holding waveform start addresses, with a
// synchronous flush. The head is forced to 0 while empty so it never shows stale data.
module trig_addr_fifo #(
  parameter int DW = 12,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // A pop is a valid/ready handshake: it takes effect only when rd_en and the
  // FIFO is non-empty in the same cycle; a push likewise needs a free slot.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/cbuf_trig_ctrl.sv
// Write-side controller for the ADC circular buffer: advances the write address,
// turns trigger edges into waveform start addresses and queues them once complete.
module cbuf_trig_ctrl
  import cbuf_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF,
  parameter int DROP_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              trig_in,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic [ADDR_W-1:0] wfm_len,
  output logic              circ_buf_we,
  output logic [ADDR_W-1:0] circ_buf_wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              trig_addr_valid,
  input  logic              trig_addr_rd_en,
  output logic              trig_accepted,
  output logic              trig_dropped,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy,
  output logic [NUM_ST-1:0] dbg_state,
  output logic [FIFO_AW:0]  dbg_fifo_count
);

  cbuf_state_e       state_q, state_d;
  logic              trig_in_d_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   prime_cnt_q, prime_cnt_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic              acc_q, acc_d;
  logic              drop_q, drop_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              trig_edge;
  logic              fifo_flush, fifo_wr, fifo_empty, fifo_full;

  assign trig_edge = trig_in & ~trig_in_d_q;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q + 1'b1;
    prime_cnt_d = prime_cnt_q;
    start_d     = start_q;
    post_d      = post_q;
    acc_d       = 1'b0;
    drop_d      = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    fifo_flush  = 1'b0;
    fifo_wr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wr_addr_d = '0;
        if (enable) begin
          state_d     = ST_PRIME;
          fifo_flush  = 1'b1;
          drop_cnt_d  = '0;
          prime_cnt_d = '0;
        end
      end
      ST_PRIME: begin
        // Count includes this cycle's write, so ARMED starts with the full pre-trigger history.
        prime_cnt_d = prime_cnt_q + 1'b1;
        if (prime_cnt_d >= {1'b0, pretrig_len}) state_d = ST_ARMED;
        if (trig_edge) drop_d = 1'b1;
      end
      ST_ARMED: begin
        if (trig_edge) begin
          if (!fifo_full) begin
            start_d = wr_addr_q - pretrig_len;
            post_d  = (wfm_len > pretrig_len) ? (wfm_len - pretrig_len) : '0;
            acc_d   = 1'b1;
            state_d = (post_d != '0) ? ST_POST : ST_PUSH;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      ST_POST: begin
        post_d = post_q - 1'b1;
        if (post_q <= 1) state_d = ST_PUSH;
        if (trig_edge) drop_d = 1'b1;
      end
      ST_PUSH: begin
        fifo_wr = 1'b1;
        state_d = ST_ARMED;
        if (trig_edge) drop_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing enable abandons any trigger in flight silently; queued addresses stay.
    if (state_q != ST_IDLE && !enable) begin
      state_d   = ST_IDLE;
      wr_addr_d = '0;
      acc_d     = 1'b0;
      drop_d    = 1'b0;
      fifo_wr   = 1'b0;
    end

    if (drop_d && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      trig_in_d_q <= 1'b1;
      wr_addr_q   <= '0;
      prime_cnt_q <= '0;
      start_q     <= '0;
      post_q      <= '0;
      acc_q       <= 1'b0;
      drop_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      trig_in_d_q <= trig_in;
      wr_addr_q   <= wr_addr_d;
      prime_cnt_q <= prime_cnt_d;
      start_q     <= start_d;
      post_q      <= post_d;
      acc_q       <= acc_d;
      drop_q      <= drop_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  trig_addr_fifo #(
    .DW (ADDR_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data (start_q),
    .rd_en   (trig_addr_rd_en),
    .rd_data (trig_addr),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (dbg_fifo_count)
  );

  assign circ_buf_we      = (state_q != ST_IDLE);
  assign circ_buf_wr_addr = wr_addr_q;
  assign trig_addr_valid  = ~fifo_empty;
  assign trig_accepted    = acc_q;
  assign trig_dropped     = drop_q;
  assign drop_cnt         = drop_cnt_q;
  assign busy             = (state_q == ST_PRIME) || (state_q == ST_POST) || (state_q == ST_PUSH);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_cbuf_trig_ctrl.sv
// Self-checking bench for cbuf_trig_ctrl: cycle-level reference model built from
// write-address/queue bookkeeping, a vector table, directed corner cases and random traffic.
module tb_cbuf_trig_ctrl;

  localparam int AW    = 12;
  localparam int FAW   = 4;
  localparam int DW    = 2;
  localparam int AMASK = (1 << AW) - 1;
  localparam int DMAX  = (1 << DW) - 1;
  localparam int FDEP  = 1 << FAW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          trig_in;
  logic [AW-1:0] pretrig_len;
  logic [AW-1:0] wfm_len;
  logic          circ_buf_we;
  logic [AW-1:0] circ_buf_wr_addr;
  logic [AW-1:0] trig_addr;
  logic          trig_addr_valid;
  logic          trig_addr_rd_en;
  logic          trig_accepted;
  logic          trig_dropped;
  logic [DW-1:0] drop_cnt;
  logic          busy;
  logic [4:0]    dbg_state;
  logic [FAW:0]  dbg_fifo_count;

  cbuf_trig_ctrl #(.ADDR_W(AW), .FIFO_AW(FAW), .DROP_W(DW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .trig_in          (trig_in),
    .pretrig_len      (pretrig_len),
    .wfm_len          (wfm_len),
    .circ_buf_we      (circ_buf_we),
    .circ_buf_wr_addr (circ_buf_wr_addr),
    .trig_addr        (trig_addr),
    .trig_addr_valid  (trig_addr_valid),
    .trig_addr_rd_en  (trig_addr_rd_en),
    .trig_accepted    (trig_accepted),
    .trig_dropped     (trig_dropped),
    .drop_cnt         (drop_cnt),
    .busy             (busy),
    .dbg_state        (dbg_state),
    .dbg_fifo_count   (dbg_fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: acquisition on/off, words written so far, pending push time.
  bit          m_on = 0, m_armed = 0, m_pending = 0, m_prev_trig = 1;
  bit          m_acc = 0, m_drp = 0;
  int          m_written = 0, m_push_cyc = 0, m_addr = 0, m_drop = 0;
  logic [AW-1:0] m_start = '0;
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit edge_s, flush, push;
    int pre, wfm, post, size0;
    edge_s = trig_in && !m_prev_trig;
    m_prev_trig = trig_in;
    m_acc = 0; m_drp = 0; flush = 0; push = 0;
    size0 = exp_q.size();
    pre = int'(pretrig_len);
    wfm = int'(wfm_len);
    if (!m_on) begin
      if (enable) begin
        m_on = 1; flush = 1; m_drop = 0; m_written = 0;
        m_armed = 0; m_pending = 0; m_addr = 0;
      end
    end else if (!enable) begin
      m_on = 0; m_pending = 0; m_addr = 0;
    end else begin
      if (!m_armed) begin
        m_written++;
        if (edge_s) m_drp = 1;
        if (m_written >= pre) m_armed = 1;
      end else if (m_pending) begin
        if (edge_s) m_drp = 1;
        if (cyc == m_push_cyc) begin
          push = 1;
          m_pending = 0;
        end
      end else if (edge_s) begin
        if (size0 < FDEP) begin
          m_start    = AW'((m_addr - pre) & AMASK);
          post       = (wfm > pre) ? wfm - pre : 0;
          m_push_cyc = cyc + post + 1;
          m_pending  = 1;
          m_acc      = 1;
        end else begin
          m_drp = 1;
        end
      end
      m_addr = (m_addr + 1) & AMASK;
    end
    if (flush) exp_q.delete();
    else if (trig_addr_rd_en && size0 > 0) void'(exp_q.pop_front());
    if (push) exp_q.push_back(m_start);
    if (m_drp && m_drop < DMAX) m_drop++;
    cyc++;
  endtask

  task automatic check_outputs();
    chk("we", circ_buf_we, m_on);
    chk("wr_addr", circ_buf_wr_addr, m_addr);
    chk("valid", trig_addr_valid, exp_q.size() > 0);
    chk("trig_addr", trig_addr, exp_q.size() > 0 ? int'(exp_q[0]) : 0);
    chk("accepted", trig_accepted, m_acc);
    chk("dropped", trig_dropped, m_drp);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("busy", busy, m_on && (!m_armed || m_pending));
    chk("fifo_count", dbg_fifo_count, exp_q.size());
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_trig();
    trig_in = 1'b1;
    cycle();
    trig_in = 1'b0;
  endtask

  task automatic start_acq(input int pre, input int wfm);
    trig_in = 1'b0;
    trig_addr_rd_en = 1'b0;
    enable = 1'b0;
    run(2);
    pretrig_len = AW'(pre);
    wfm_len = AW'(wfm);
    enable = 1'b1;
    cycle();
  endtask

  task automatic wait_armed();
    int k;
    k = 0;
    while (!(m_on && m_armed && !m_pending) && k < 10000) begin
      cycle();
      k++;
    end
    if (k >= 10000) chk("wait_armed timeout", 1, 0);
  endtask

  typedef struct {
    int pre;
    int wfm;
    int at_addr;
    int exp_addr;
    int exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k, lat;

    vecs[0] = '{8,   32,  100, 92,   26};
    vecs[1] = '{10,  20,  3,   4089, 12};
    vecs[2] = '{16,  16,  200, 184,  2};
    vecs[3] = '{20,  5,   50,  30,   2};
    vecs[4] = '{0,   1,   7,   7,    3};
    vecs[5] = '{100, 300, 150, 50,   202};

    // Clock/reset: trigger held high across reset release must not fire.
    reset_n = 1'b0;
    enable = 1'b0;
    trig_in = 1'b1;
    trig_addr_rd_en = 1'b0;
    pretrig_len = '0;
    wfm_len = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_outputs();
    chk("reset busy", busy, 0);
    chk("reset drop_cnt", drop_cnt, 0);
    run(4);
    chk("trig high at reset: accepted", trig_accepted, 0);
    chk("trig high at reset: dropped", trig_dropped, 0);
    chk("idle we", circ_buf_we, 0);

    pretrig_len = 12'd4;
    wfm_len = 12'd8;
    enable = 1'b1;
    cycle();
    chk("first write we", circ_buf_we, 1);
    chk("first write addr", circ_buf_wr_addr, 0);
    trig_in = 1'b0;
    run(2);
    chk("second write addr", circ_buf_wr_addr, 2);

    // Vector table: start address and edge-to-valid latency.
    foreach (vecs[i]) begin
      start_acq(vecs[i].pre, vecs[i].wfm);
      k = 0;
      while (!(m_armed && !m_pending && m_addr == vecs[i].at_addr) && k < 10000) begin
        cycle();
        k++;
      end
      if (k >= 10000) chk("vec wait timeout", 1, 0);
      pulse_trig();
      chk("vec accepted pulse", trig_accepted, 1);
      lat = 1;
      while (!trig_addr_valid && lat < 5000) begin
        cycle();
        lat++;
      end
      chk("vec latency", lat, vecs[i].exp_lat);
      chk("vec trig_addr", trig_addr, vecs[i].exp_addr);
      trig_addr_rd_en = 1'b1;
      cycle();
      trig_addr_rd_en = 1'b0;
      chk("vec pop empties", trig_addr_valid, 0);
    end

    // Drops in PRIME and POST, then saturation of the counter.
    start_acq(50, 100);
    pulse_trig();
    chk("prime drop pulse", trig_dropped, 1);
    cycle();
    wait_armed();
    pulse_trig();
    chk("armed accept pulse", trig_accepted, 1);
    run(5);
    pulse_trig();
    chk("post drop pulse", trig_dropped, 1);
    chk("drop_cnt after two", drop_cnt, 2);
    chk("fifo empty after drops", trig_addr_valid, 0);
    cycle();
    pulse_trig();
    chk("drop_cnt all ones", drop_cnt, DMAX);
    cycle();
    pulse_trig();
    chk("saturated drop pulse", trig_dropped, 1);
    chk("drop_cnt saturated", drop_cnt, DMAX);

    // Fill the FIFO, drop on full, pop one, accept again.
    start_acq(2, 2);
    wait_armed();
    for (int i = 0; i < FDEP; i++) begin
      pulse_trig();
      run(3);
    end
    chk("fifo full count", dbg_fifo_count, FDEP);
    pulse_trig();
    chk("full drop pulse", trig_dropped, 1);
    cycle();
    chk("full count kept", dbg_fifo_count, FDEP);
    trig_addr_rd_en = 1'b1;
    cycle();
    trig_addr_rd_en = 1'b0;
    chk("count after pop", dbg_fifo_count, FDEP - 1);
    pulse_trig();
    chk("accept after pop", trig_accepted, 1);
    run(3);
    chk("refilled count", dbg_fifo_count, FDEP);

    // Enable dropped mid-POST, then re-enabled.
    start_acq(4, 40);
    wait_armed();
    pulse_trig();
    run(5);
    enable = 1'b0;
    cycle();
    chk("disable we", circ_buf_we, 0);
    chk("disable busy", busy, 0);
    run(60);
    chk("no push after disable", trig_addr_valid, 0);
    pulse_trig();
    enable = 1'b1;
    cycle();
    chk("reenable we", circ_buf_we, 1);
    chk("reenable addr", circ_buf_wr_addr, 0);
    chk("reenable drop_cnt", drop_cnt, 0);

    // Random traffic against the model.
    for (int ep = 0; ep < 12; ep++) begin
      enable = 1'b0;
      run($urandom_range(1, 5));
      pretrig_len = AW'($urandom_range(0, 40));
      wfm_len = AW'($urandom_range(0, 80));
      enable = 1'b1;
      repeat ($urandom_range(150, 500)) begin
        trig_in = ($urandom_range(0, 99) < 15);
        trig_addr_rd_en = ($urandom_range(0, 99) < 10);
        cycle();
      end
      trig_addr_rd_en = 1'b0;
    end
    enable = 1'b0;
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
